uvmt_cv32e40s_sl_trigger_debug_entry: RTL and testbench
=======================================================

Name: uvmt_cv32e40s_sl_trigger_debug_entry

Overview:
- Support-logic stage directly downstream of the trigger-match model.
- Consumes per-retirement trigger-match vectors and tracks, per trigger, a sticky hit status and a saturating match count.
- Enforces the required consequence of a match: the next retirement is in debug mode, with DPC equal to the matching PC and dcsr.cause = trigger (2).
- Outputs feed debug assertions and coverage in the uvmt bench.

Parameters:
- NUM_TRIGGERS, default CORE_PARAM_DBG_NUM_TRIGGERS: number of trigger units modelled.
- CNT_W, default 8: width of each per-trigger match counter; saturates.
- TIMEOUT, default 64: maximum cycles from a match retirement to the debug-entry retirement.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- rvfi_valid_i  input  1  instruction retirement strobe.
- rvfi_dbg_mode_i  input  1  retiring instruction executed in debug mode.
- rvfi_pc_rdata_i  input  32  PC of the retiring instruction.
- rvfi_dpc_i  input  32  DPC CSR value seen at retirement.
- rvfi_dcsr_cause_i  input  3  dcsr.cause seen at retirement.
- is_trigger_match_i  input  NUM_TRIGGERS  per-trigger match on the current retirement (mem|execute|exception).
- tdata1_wr_i  input  1  retirement writes tdata1.
- tselect_i  input  $clog2(NUM_TRIGGERS)  trigger addressed by tdata1_wr_i.
- hit_o  output  NUM_TRIGGERS  sticky per-trigger hit status.
- match_cnt_o  output  NUM_TRIGGERS*CNT_W  packed saturating match counters.
- entry_pending_o  output  1  a match has retired and debug entry has not yet been observed.
- expected_dpc_o  output  32  PC latched at the match.
- entry_err_o  output  1  one-cycle pulse on a failed entry check.
- timeout_err_o  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-PENDING abandons the check with no error pulse.
- A match event is rvfi_valid_i && |is_trigger_match_i && !rvfi_dbg_mode_i. Matches while in debug mode are ignored.
- On a match event:
  - hit_o[t] is set for each matching t on the next edge.
  - match_cnt[t] increments and holds at 2^CNT_W-1.
- tdata1_wr_i && rvfi_valid_i clears hit_o[tselect_i] on the next edge. A set in the same cycle for the same trigger wins.
- FSM state IDLE:
  - On a match event, latch rvfi_pc_rdata_i into expected_dpc_o, clear the timer and go to PENDING.
  - entry_pending_o = 1 starting the following cycle.
- FSM state PENDING: the timer increments every cycle. On the next rvfi_valid_i:
  - Pass when rvfi_dbg_mode_i == 1 && rvfi_dpc_i == expected_dpc_o && rvfi_dcsr_cause_i == 3'd2. Go to IDLE with no pulse.
  - Otherwise, pulse entry_err_o for one cycle (registered, 1-cycle latency after the retirement) and go to IDLE.
  - A retirement in PENDING that is itself a match event still updates hit_o and the counters, but does not relatch the PC. The error is reported instead.
- Timeout: if the timer reaches TIMEOUT with no retirement, pulse timeout_err_o, go to IDLE and stop the timer.
- Retirement on the exact TIMEOUT cycle: the retirement check takes priority, so only one pulse is raised.
- Timer width is $clog2(TIMEOUT+1). It never wraps.
- entry_err_o and timeout_err_o are never asserted in the same cycle.

Decomposition:
- Package uvmt_cv32e40s_base_test_pkg holds:
  - DBG_CAUSE_TRIGGER = 3'd2.
  - The FSM state enum typedef (IDLE, PENDING).
- Sub-module uvmt_cv32e40s_sl_trigger_hit_counter: one per trigger, via generate. It owns the sticky hit bit and the saturating counter, and takes set/clear/increment inputs.
- The top level holds the FSM, the timer and the PC latch.

Test Plan:
- Match on trigger 1 at pc 0x0000_1000; the next retirement has dbg_mode=1, dpc=0x1000, cause=2 -> hit_o=0b0010, match_cnt[1]=1, no error pulse, entry_pending_o drops.
- Match at pc 0x2000; the next retirement has dbg_mode=0 -> entry_err_o pulses for exactly one cycle; FSM returns to IDLE.
- Match at pc 0x3000; the next retirement has dpc=0x3004 or cause=3 -> entry_err_o pulses once.
- Match, then no retirement for 64 cycles -> timeout_err_o pulses at cycle 64; a retirement on the same cycle instead yields only the check result.
- 300 matches on trigger 0 with CNT_W=8 -> match_cnt[0] holds at 255.
- tdata1 write with tselect=0 while hit_o[0]=1 -> hit_o[0]=0 next cycle; a simultaneous match on trigger 0 keeps it at 1.
- Assert rst_i asynchronously while in PENDING -> outputs 0 immediately; no error pulse after release.

Source files
------------

// File: rtl/uvmt_cv32e40s_base_test_pkg.sv
// uvmt_cv32e40s_base_test_pkg: shared constants and types for the trigger debug-entry support logic
package uvmt_cv32e40s_base_test_pkg;

   localparam int CORE_PARAM_DBG_NUM_TRIGGERS = 4;

   localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;

   typedef enum logic {
      IDLE,
      PENDING
   } sl_trig_state_e;

endpackage

// File: rtl/uvmt_cv32e40s_sl_trigger_hit_counter.sv
// uvmt_cv32e40s_sl_trigger_hit_counter: sticky hit bit and saturating match counter for one trigger
module uvmt_cv32e40s_sl_trigger_hit_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             set,
   input  logic             clr,
   input  logic             inc,
   output logic             hit,
   output logic [CNT_W-1:0] cnt
);

   // a set beats a clear on the same edge; the counter holds once all ones
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit <= 1'b0;
         cnt <= '0;
      end else begin
         hit <= set | (hit & ~clr);
         cnt <= (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
      end
   end

endmodule

// File: rtl/uvmt_cv32e40s_sl_trigger_debug_entry.sv
// uvmt_cv32e40s_sl_trigger_debug_entry: checks that a trigger match retirement is followed by trigger debug entry
module uvmt_cv32e40s_sl_trigger_debug_entry
   import uvmt_cv32e40s_base_test_pkg::*;
#(
   parameter int NUM_TRIGGERS = CORE_PARAM_DBG_NUM_TRIGGERS,
   parameter int CNT_W        = 8,
   parameter int TIMEOUT      = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            rvfi_valid_i,
   input  logic                            rvfi_dbg_mode_i,
   input  logic [31:0]                     rvfi_pc_rdata_i,
   input  logic [31:0]                     rvfi_dpc_i,
   input  logic [2:0]                      rvfi_dcsr_cause_i,
   input  logic [NUM_TRIGGERS-1:0]         is_trigger_match_i,
   input  logic                            tdata1_wr_i,
   input  logic [$clog2(NUM_TRIGGERS)-1:0] tselect_i,
   output logic [NUM_TRIGGERS-1:0]         hit_o,
   output logic [NUM_TRIGGERS*CNT_W-1:0]   match_cnt_o,
   output logic                            entry_pending_o,
   output logic [31:0]                     expected_dpc_o,
   output logic                            entry_err_o,
   output logic                            timeout_err_o
);

   localparam int TSEL_W = $clog2(NUM_TRIGGERS);
   localparam int TMR_W  = $clog2(TIMEOUT + 1);

   sl_trig_state_e state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [31:0] dpc_d;
   logic entry_err_d, timeout_err_d;
   logic match_ev, entry_ok;

   assign match_ev        = rvfi_valid_i && |is_trigger_match_i && !rvfi_dbg_mode_i;
   assign entry_ok        = rvfi_dbg_mode_i && rvfi_dpc_i == expected_dpc_o && rvfi_dcsr_cause_i == DBG_CAUSE_TRIGGER;
   assign entry_pending_o = state_q == PENDING;

   for (genvar t = 0; t < NUM_TRIGGERS; t++) begin : g_trig
      logic set;
      assign set = match_ev && is_trigger_match_i[t];
      uvmt_cv32e40s_sl_trigger_hit_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .set   (set),
         .clr   (tdata1_wr_i && rvfi_valid_i && tselect_i == TSEL_W'(t)),
         .inc   (set),
         .hit   (hit_o[t]),
         .cnt   (match_cnt_o[t*CNT_W +: CNT_W])
      );
   end

   // next state: latch the PC on a match, then judge the first retirement or give up after TIMEOUT cycles
   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      dpc_d         = expected_dpc_o;
      entry_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      if (state_q == IDLE) begin
         if (match_ev) begin
            state_d = PENDING;
            tmr_d   = '0;
            dpc_d   = rvfi_pc_rdata_i;
         end
      end else begin
         tmr_d = (tmr_q == TMR_W'(TIMEOUT)) ? tmr_q : tmr_q + 1'b1;
         if (rvfi_valid_i) begin
            state_d     = IDLE;
            entry_err_d = !entry_ok;
         end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
         end
      end
   end

   // state, timer, latched PC and registered error pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         tmr_q          <= '0;
         expected_dpc_o <= '0;
         entry_err_o    <= 1'b0;
         timeout_err_o  <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_q          <= tmr_d;
         expected_dpc_o <= dpc_d;
         entry_err_o    <= entry_err_d;
         timeout_err_o  <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_uvmt_cv32e40s_sl_trigger_debug_entry.sv
// tb_uvmt_cv32e40s_sl_trigger_debug_entry: random and directed checks against a retirement-level reference model
module tb_uvmt_cv32e40s_sl_trigger_debug_entry;

   localparam int NT = 4;
   localparam int CW = 8;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst_i = 1'b1;
   logic rvfi_valid_i = 1'b0;
   logic rvfi_dbg_mode_i = 1'b0;
   logic [31:0] rvfi_pc_rdata_i = '0;
   logic [31:0] rvfi_dpc_i = '0;
   logic [2:0] rvfi_dcsr_cause_i = '0;
   logic [NT-1:0] is_trigger_match_i = '0;
   logic tdata1_wr_i = 1'b0;
   logic [1:0] tselect_i = '0;
   logic [NT-1:0] hit_o;
   logic [NT*CW-1:0] match_cnt_o;
   logic entry_pending_o;
   logic [31:0] expected_dpc_o;
   logic entry_err_o;
   logic timeout_err_o;

   always #5 clk = ~clk;

   uvmt_cv32e40s_sl_trigger_debug_entry #(.NUM_TRIGGERS(NT), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .rvfi_valid_i       (rvfi_valid_i),
      .rvfi_dbg_mode_i    (rvfi_dbg_mode_i),
      .rvfi_pc_rdata_i    (rvfi_pc_rdata_i),
      .rvfi_dpc_i         (rvfi_dpc_i),
      .rvfi_dcsr_cause_i  (rvfi_dcsr_cause_i),
      .is_trigger_match_i (is_trigger_match_i),
      .tdata1_wr_i        (tdata1_wr_i),
      .tselect_i          (tselect_i),
      .hit_o              (hit_o),
      .match_cnt_o        (match_cnt_o),
      .entry_pending_o    (entry_pending_o),
      .expected_dpc_o     (expected_dpc_o),
      .entry_err_o        (entry_err_o),
      .timeout_err_o      (timeout_err_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   logic [NT-1:0] m_hit;
   int m_cnt[NT];
   bit m_pend;
   logic [31:0] m_epc;
   int m_dist;
   bit m_eerr, m_terr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hit = '0;
      foreach (m_cnt[t]) m_cnt[t] = 0;
      m_pend = 0;
      m_epc = '0;
      m_dist = 0;
      m_eerr = 0;
      m_terr = 0;
   endtask

   // one retirement slot: update hit/count bookkeeping, then the debug-entry obligation
   task automatic model_step();
      bit mev;
      mev = rvfi_valid_i && (is_trigger_match_i != '0) && !rvfi_dbg_mode_i;
      for (int t = 0; t < NT; t++) begin
         if (mev && is_trigger_match_i[t]) begin
            m_hit[t] = 1'b1;
            if (m_cnt[t] < (1 << CW) - 1) m_cnt[t]++;
         end else if (rvfi_valid_i && tdata1_wr_i && int'(tselect_i) == t) begin
            m_hit[t] = 1'b0;
         end
      end
      m_eerr = 0;
      m_terr = 0;
      if (!m_pend) begin
         if (mev) begin
            m_pend = 1;
            m_epc = rvfi_pc_rdata_i;
            m_dist = 0;
         end
      end else begin
         m_dist++;
         if (rvfi_valid_i) begin
            m_pend = 0;
            m_eerr = !(rvfi_dbg_mode_i && rvfi_dpc_i == m_epc && rvfi_dcsr_cause_i == 3'd2);
         end else if (m_dist == TO) begin
            m_pend = 0;
            m_terr = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("hit", hit_o, m_hit);
      for (int t = 0; t < NT; t++) chk($sformatf("cnt%0d", t), match_cnt_o[t*CW +: CW], m_cnt[t]);
      chk("pending", entry_pending_o, m_pend);
      chk("exp_dpc", expected_dpc_o, m_epc);
      chk("entry_err", entry_err_o, m_eerr);
      chk("timeout_err", timeout_err_o, m_terr);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1 check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic ret(input logic [31:0] pc, input bit dbg, input logic [31:0] dpc, input logic [2:0] cause,
                      input logic [NT-1:0] m, input bit wr, input logic [1:0] ts);
      rvfi_valid_i = 1'b1;
      rvfi_pc_rdata_i = pc;
      rvfi_dbg_mode_i = dbg;
      rvfi_dpc_i = dpc;
      rvfi_dcsr_cause_i = cause;
      is_trigger_match_i = m;
      tdata1_wr_i = wr;
      tselect_i = ts;
      cyc();
      rvfi_valid_i = 1'b0;
      is_trigger_match_i = '0;
      tdata1_wr_i = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 check_all();
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      idle(2);
      // good entry after a trigger 1 match
      ret(32'h1000, 0, 0, 0, 4'b0010, 0, 0);
      ret(32'h1004, 1, 32'h1000, 3'd2, 0, 0, 0);
      idle(2);
      chk("t1_hit_const", hit_o, 4'b0010);
      chk("t1_cnt1_const", match_cnt_o[CW +: CW], 1);
      // next retirement not in debug mode
      ret(32'h2000, 0, 0, 0, 4'b0001, 0, 0);
      ret(32'h2004, 0, 32'h2000, 3'd2, 0, 0, 0);
      idle(2);
      // wrong dpc, then wrong cause
      ret(32'h3000, 0, 0, 0, 4'b0100, 0, 0);
      ret(32'h3004, 1, 32'h3004, 3'd2, 0, 0, 0);
      idle(1);
      ret(32'h3000, 0, 0, 0, 4'b0100, 0, 0);
      ret(32'h3004, 1, 32'h3000, 3'd3, 0, 0, 0);
      idle(2);
      // timeout, then retirements landing on the last allowed cycle
      ret(32'h4000, 0, 0, 0, 4'b1000, 0, 0);
      idle(TO + 4);
      ret(32'h5000, 0, 0, 0, 4'b1000, 0, 0);
      idle(TO - 1);
      ret(32'h5004, 1, 32'h5000, 3'd2, 0, 0, 0);
      idle(3);
      ret(32'h5100, 0, 0, 0, 4'b1000, 0, 0);
      idle(TO - 1);
      ret(32'h5104, 0, 32'h5100, 3'd2, 0, 0, 0);
      idle(3);
      // counter saturation on trigger 0
      for (int i = 0; i < 300; i++) ret(32'h6000 + 4 * i, 0, 0, 0, 4'b0001, 0, 0);
      idle(2);
      chk("sat_cnt0_const", match_cnt_o[0 +: CW], 255);
      // tdata1 write clears, simultaneous match wins
      ret(32'h7000, 1, 0, 0, 0, 1, 0);
      idle(1);
      chk("clr_hit0_const", hit_o[0], 1'b0);
      ret(32'h7100, 0, 0, 0, 4'b0001, 0, 0);
      ret(32'h7104, 0, 0, 0, 4'b0001, 1, 0);
      idle(2);
      chk("set_wins_const", hit_o[0], 1'b1);
      // randomized traffic, alternating dense and sparse retirement phases
      for (int i = 0; i < 4000; i++) begin
         int div;
         div = ((i / 500) % 2) != 0 ? 90 : 3;
         rvfi_valid_i = ($urandom % div) == 0;
         rvfi_pc_rdata_i = $urandom & 32'hffff_fffc;
         rvfi_dbg_mode_i = ($urandom % 4) != 0;
         rvfi_dpc_i = ($urandom % 4) == 0 ? $urandom : m_epc;
         rvfi_dcsr_cause_i = ($urandom % 5) == 0 ? 3'($urandom) : 3'd2;
         if (($urandom % 3) == 0) begin
            rvfi_dbg_mode_i = 1'b0;
            is_trigger_match_i = NT'($urandom);
         end else begin
            is_trigger_match_i = '0;
         end
         tdata1_wr_i = ($urandom % 6) == 0;
         tselect_i = 2'($urandom);
         cyc();
      end
      rvfi_valid_i = 1'b0;
      is_trigger_match_i = '0;
      tdata1_wr_i = 1'b0;
      idle(TO + 2);
      // asynchronous reset while pending
      ret(32'h8000, 0, 0, 0, 4'b0110, 0, 0);
      idle(5);
      chk("pend_before_rst", entry_pending_o, 1'b1);
      #3 rst_i = 1'b1;
      #1 model_reset();
      check_all();
      @(posedge clk);
      #2 rst_i = 1'b0;
      idle(TO + 4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
